// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice: instruction encoding,
// ALU datapath width and the idle instruction driven when nobody is granted.
package alu_arbiter_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    INST_NOP  = 4'h0,
    INST_ADD  = 4'h1,
    INST_SUB  = 4'h2,
    INST_AND  = 4'h3,
    INST_OR   = 4'h4,
    INST_XOR  = 4'h5,
    INST_SLL  = 4'h6,
    INST_SRL  = 4'h7,
    INST_SRA  = 4'h8,
    INST_SLT  = 4'h9,
    INST_SLTU = 4'hA,
    INST_SLLI = 4'hB,
    INST_SRLI = 4'hC,
    INST_SRAI = 4'hD
  } inst_e;

  localparam inst_e INST_DEFAULT = INST_NOP;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between N_REQ requesters (master) and the shared
// ALU arbiter (slave).
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  inst_e                        req_inst [N_REQ];
  logic [N_REQ-1:0][ALU_W-1:0]  req_op_a;
  logic [N_REQ-1:0][ALU_W-1:0]  req_op_b;
  logic [N_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0]             rsp_ready;
  logic [ALU_W-1:0]             rsp_result;
  logic [TAG_W-1:0]             rsp_tag;

  modport master (
    output req_valid, req_inst, req_op_a, req_op_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_inst, req_op_a, req_op_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit integer ALU; unknown instructions produce zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  inst_e             inst_i,
  input  logic [ALU_W-1:0]  op_a_i,
  input  logic [ALU_W-1:0]  op_b_i,
  output logic [ALU_W-1:0]  result_o
);
  logic [4:0] shamt;

  always_comb begin
    shamt    = op_b_i[4:0];
    result_o = '0;
    case (inst_i)
      INST_ADD:             result_o = op_a_i + op_b_i;
      INST_SUB:             result_o = op_a_i - op_b_i;
      INST_AND:             result_o = op_a_i & op_b_i;
      INST_OR:              result_o = op_a_i | op_b_i;
      INST_XOR:             result_o = op_a_i ^ op_b_i;
      INST_SLL, INST_SLLI:  result_o = op_a_i << shamt;
      INST_SRL, INST_SRLI:  result_o = op_a_i >> shamt;
      INST_SRA, INST_SRAI:  result_o = $unsigned($signed(op_a_i) >>> shamt);
      INST_SLT:             result_o = {{(ALU_W-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      INST_SLTU:            result_o = {{(ALU_W-1){1'b0}}, op_a_i < op_b_i};
      default:              result_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter_rr.sv
// Request arbiter: rotating priority starting after last_grant, or fixed
// lowest-index priority. Reusable for other shared execute units.
module rr_arbiter #(
  parameter int N_REQ       = 2,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [N_REQ-1:0] gnt_oh_o
);
  logic [IDX_W-1:0] cand;

  // Scan from the lowest-priority candidate upward so the last hit wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    gnt_oh_o    = '0;
    cand        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (ROUND_ROBIN)
        cand = IDX_W'((int'(last_grant_i) + k) % N_REQ);
      else
        cand = IDX_W'(k - 1);
      if (req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
    if (gnt_valid_o)
      gnt_oh_o[gnt_idx_o] = 1'b1;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters and returns each
// result through a single registered response slot tagged with its owner.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TAG_W       = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  alu_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_oh;

  logic             slot_valid_q, slot_valid_d;
  logic [IDX_W-1:0] slot_owner_q, slot_owner_d;
  logic [ALU_W-1:0] slot_result_q, slot_result_d;
  logic [TAG_W-1:0] slot_tag_q, slot_tag_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  inst_e            alu_inst;
  logic [ALU_W-1:0] alu_a, alu_b, alu_res;
  logic             drain, free, accept;
  logic [N_REQ-1:0] rsp_valid_oh;

  rr_arbiter #(.N_REQ(N_REQ), .ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx),
    .gnt_oh_o     (gnt_oh)
  );

  alu u_alu (
    .inst_i   (alu_inst),
    .op_a_i   (alu_a),
    .op_b_i   (alu_b),
    .result_o (alu_res)
  );

  always_comb begin
    drain    = slot_valid_q && bus.rsp_ready[slot_owner_q];
    free     = !slot_valid_q || drain;
    accept   = gnt_valid && free;
    alu_inst = INST_DEFAULT;
    alu_a    = '0;
    alu_b    = '0;
    if (gnt_valid) begin
      alu_inst = bus.req_inst[gnt_idx];
      alu_a    = bus.req_op_a[gnt_idx];
      alu_b    = bus.req_op_b[gnt_idx];
    end
  end

  // A drain and a fresh accept in the same edge simply overwrite the slot.
  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_owner_d  = slot_owner_q;
    slot_result_d = slot_result_q;
    slot_tag_d    = slot_tag_q;
    last_grant_d  = last_grant_q;
    if (accept) begin
      slot_valid_d  = 1'b1;
      slot_owner_d  = gnt_idx;
      slot_result_d = alu_res;
      slot_tag_d    = bus.req_tag[gnt_idx];
      last_grant_d  = gnt_idx;
    end else if (drain) begin
      slot_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q  <= 1'b0;
      slot_owner_q  <= '0;
      slot_result_q <= '0;
      slot_tag_q    <= '0;
      last_grant_q  <= IDX_W'(N_REQ - 1);
    end else begin
      slot_valid_q  <= slot_valid_d;
      slot_owner_q  <= slot_owner_d;
      slot_result_q <= slot_result_d;
      slot_tag_q    <= slot_tag_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    rsp_valid_oh               = '0;
    rsp_valid_oh[slot_owner_q] = slot_valid_q;
  end

  assign bus.req_ready  = accept ? gnt_oh : '0;
  assign bus.rsp_valid  = rsp_valid_oh;
  assign bus.rsp_result = slot_result_q;
  assign bus.rsp_tag    = slot_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance sharing clock and reset.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.N_REQ(2), .TAG_W(4)) bus_rr ();
  alu_arbiter_if #(.N_REQ(2), .TAG_W(4)) bus_fp ();

  alu_arbiter #(.N_REQ(2), .TAG_W(4), .ROUND_ROBIN(1'b1)) u_rr (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_rr)
  );
  alu_arbiter #(.N_REQ(2), .TAG_W(4), .ROUND_ROBIN(1'b0)) u_fp (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_fp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_rr.req_valid = '0; bus_rr.rsp_ready = '0;
    bus_rr.req_op_a  = '0; bus_rr.req_op_b  = '0; bus_rr.req_tag = '0;
    bus_fp.req_valid = '0; bus_fp.rsp_ready = '0;
    bus_fp.req_op_a  = '0; bus_fp.req_op_b  = '0; bus_fp.req_tag = '0;
    for (int p = 0; p < 2; p++) begin
      bus_rr.req_inst[p] = INST_NOP;
      bus_fp.req_inst[p] = INST_NOP;
    end
  endtask

  task automatic drv_rr(input int p, input inst_e inst, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
    bus_rr.req_valid[p] = 1'b1;
    bus_rr.req_inst[p]  = inst;
    bus_rr.req_op_a[p]  = a;
    bus_rr.req_op_b[p]  = b;
    bus_rr.req_tag[p]   = tag;
  endtask

  task automatic drv_fp(input int p, input inst_e inst, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
    bus_fp.req_valid[p] = 1'b1;
    bus_fp.req_inst[p]  = inst;
    bus_fp.req_op_a[p]  = a;
    bus_fp.req_op_b[p]  = b;
    bus_fp.req_tag[p]   = tag;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] v,
                         input logic [31:0] res, input logic [3:0] t);
    chk({tag, "_valid"},  32'(bus_rr.rsp_valid),  32'(v));
    chk({tag, "_result"}, bus_rr.rsp_result,      res);
    chk({tag, "_tag"},    32'(bus_rr.rsp_tag),    32'(t));
  endtask

  initial begin
    int n0, n1, p;
    rst_n = 1'b0;
    idle();
    repeat (2) tick();

    chk_rsp("reset", 2'b00, 32'h0, 4'h0);
    chk("reset_ready", 32'(bus_rr.req_ready), 32'h0);
    rst_n = 1'b1;

    // Single ops on port 0, including shift-amount masking.
    bus_rr.rsp_ready = 2'b11;
    drv_rr(0, INST_SLL, 32'h0000_0001, 32'h0000_0004, 4'd3);
    #1 chk("sll_ready", 32'(bus_rr.req_ready), 32'h1);
    tick();
    chk_rsp("sll", 2'b01, 32'h0000_0010, 4'd3);

    drv_rr(0, INST_SRA, 32'h8000_0000, 32'h0000_0024, 4'd5);
    tick();
    chk_rsp("sra", 2'b01, 32'hF800_0000, 4'd5);

    drv_rr(0, INST_SRL, 32'h8000_0000, 32'h0000_0024, 4'd6);
    tick();
    chk_rsp("srl", 2'b01, 32'h0800_0000, 4'd6);

    // Port 1 alone with an unsupported encoding: ALU default of zero.
    bus_rr.req_valid = '0;
    drv_rr(1, inst_e'(4'hF), 32'h5, 32'h7, 4'd9);
    #1 chk("p1_ready", 32'(bus_rr.req_ready), 32'h2);
    tick();
    chk_rsp("unsup", 2'b10, 32'h0, 4'd9);

    // Both ports busy: accepts alternate 0,1,... with no bubbles.
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      p = i % 2;
      bus_rr.req_valid = '0;
      if (n0 < 5) drv_rr(0, INST_ADD, 32'h100 + 32'(n0), 32'h10, 4'(n0));
      if (n1 < 5) drv_rr(1, INST_ADD, 32'h200 + 32'(n1), 32'h20, 4'(8 + n1));
      #1 chk("rr_ready", 32'(bus_rr.req_ready), 32'(1 << p));
      tick();
      if (p == 0) begin
        chk_rsp("rr_p0", 2'b01, 32'h110 + 32'(n0), 4'(n0));
        n0++;
      end else begin
        chk_rsp("rr_p1", 2'b10, 32'h220 + 32'(n1), 4'(8 + n1));
        n1++;
      end
    end

    // Port 1 owns the slot but is not ready: everything stalls.
    bus_rr.req_valid = '0;
    bus_rr.rsp_ready = 2'b01;
    drv_rr(0, INST_SUB, 32'd10, 32'd3, 4'd2);
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_ready", 32'(bus_rr.req_ready), 32'h0);
      chk_rsp("bp_hold", 2'b10, 32'h224, 4'd12);
      tick();
    end
    bus_rr.rsp_ready = 2'b11;
    #1 chk("bp_release_ready", 32'(bus_rr.req_ready), 32'h1);
    tick();
    chk_rsp("bp_accept", 2'b01, 32'd7, 4'd2);

    bus_rr.req_valid = '0;
    tick();
    chk("drain_valid", 32'(bus_rr.rsp_valid), 32'h0);

    // Reset while a response is held; last_grant moved to 0 beforehand.
    drv_rr(0, INST_XOR, 32'hF0, 32'hFF, 4'd4);
    tick();
    chk_rsp("pre_rst", 2'b01, 32'h0F, 4'd4);
    bus_rr.req_valid = '0;
    bus_rr.rsp_ready = 2'b00;
    tick();
    chk("held_valid", 32'(bus_rr.rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1 chk_rsp("mid_rst", 2'b00, 32'h0, 4'h0);
    chk("mid_rst_ready", 32'(bus_rr.req_ready), 32'h0);
    tick();
    #2 rst_n = 1'b1;
    #1 chk("post_rst_valid", 32'(bus_rr.rsp_valid), 32'h0);
    bus_rr.rsp_ready = 2'b11;
    drv_rr(0, INST_ADD, 32'd1, 32'd1, 4'd1);
    drv_rr(1, INST_ADD, 32'd2, 32'd2, 4'd7);
    #1 chk("post_rst_ready", 32'(bus_rr.req_ready), 32'h1);
    tick();
    chk_rsp("post_rst", 2'b01, 32'd2, 4'd1);
    bus_rr.req_valid = '0;

    // Fixed priority: port 0 wins every cycle, port 1 starves.
    bus_fp.rsp_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      drv_fp(0, INST_ADD, 32'(n), 32'h40, 4'(n));
      drv_fp(1, INST_SUB, 32'd9, 32'd1, 4'd15);
      #1 chk("fp_ready", 32'(bus_fp.req_ready), 32'h1);
      tick();
      chk("fp_valid",  32'(bus_fp.rsp_valid), 32'h1);
      chk("fp_result", bus_fp.rsp_result,     32'h40 + 32'(n));
      chk("fp_tag",    32'(bus_fp.rsp_tag),   32'(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
